// File: rtl/usb_data_buffer_if.sv
// Handshake/data bundle between the AHB slave, the USB packet engines and the shared endpoint buffer.
interface usb_data_buffer_if;
    logic       clear;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_rx_data;
    logic [7:0] rx_data;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       buffer_error;

    modport master (
        output clear, store_tx_data, tx_data, get_rx_data,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        input  rx_data, tx_packet_data, buffer_occupancy, buffer_error
    );

    modport slave (
        input  clear, store_tx_data, tx_data, get_rx_data,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        output rx_data, tx_packet_data, buffer_occupancy, buffer_error
    );
endinterface

// File: rtl/usb_data_buffer.sv
// Shared 64-byte endpoint FIFO: AHB slave and USB RX engine push, AHB slave and USB TX engine pop.
module usb_data_buffer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic               clk,
    input  logic               n_rst,
    usb_data_buffer_if.slave   bus
);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic [7:0]        tx_packet_data_q, tx_packet_data_d;
    logic              error_q, error_d;

    logic       push_req, pop_req, push_ok, pop_ok, pop_sel_rx, err_set;
    logic [7:0] push_byte;

    // Full/empty decisions use the occupancy before the edge, so a push+pop
    // on an empty buffer rejects the pop and on a full buffer rejects the push.
    assign push_req   = bus.store_tx_data | bus.store_rx_packet_data;
    assign pop_req    = bus.get_rx_data | bus.get_tx_packet_data;
    assign push_byte  = bus.store_tx_data ? bus.tx_data : bus.rx_packet_data;
    assign pop_sel_rx = bus.get_rx_data;
    assign push_ok    = push_req && (count_q < CNT_FULL);
    assign pop_ok     = pop_req && (count_q != '0);
    assign err_set    = (bus.store_tx_data && bus.store_rx_packet_data)
                      || (bus.get_rx_data && bus.get_tx_packet_data)
                      || (push_req && !push_ok)
                      || (pop_req && !pop_ok);

    always_comb begin
        mem_d            = mem_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        rx_data_d        = rx_data_q;
        tx_packet_data_d = tx_packet_data_q;
        error_d          = error_q;

        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            error_d  = 1'b0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_byte;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (pop_sel_rx) begin
                    rx_data_d = mem_q[rd_ptr_q];
                end else begin
                    tx_packet_data_d = mem_q[rd_ptr_q];
                end
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (err_set) begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            rx_data_q        <= '0;
            tx_packet_data_q <= '0;
            error_q          <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            rx_data_q        <= rx_data_d;
            tx_packet_data_q <= tx_packet_data_d;
            error_q          <= error_d;
        end
    end

    // Storage contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.rx_data          = rx_data_q;
    assign bus.tx_packet_data   = tx_packet_data_q;
    assign bus.buffer_occupancy = count_q;
    assign bus.buffer_error     = error_q;
endmodule
